// File: rtl/cmp_result_outpkt_pkg.sv
// Shared constants and types for the CMP_RESULT output packetizer.
package cmp_result_outpkt_pkg;

    localparam logic [7:0] PKT_TYPE_CMP_RESULT = 8'hD4;
    localparam logic [7:0] PKT_COMM_VERSION    = 8'd2;
    localparam int         HDR_WORDS           = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_HCSUM,
        ST_DATA,
        ST_DCSUM
    } state_t;

    typedef struct packed {
        logic [15:0] pkt_id;
        logic [15:0] word_id;
        logic [31:0] gen_id;
        logic [15:0] hash_num;
    } ids_t;

endpackage

// File: rtl/outpkt_csum32.sv
// Running 32-bit checksum over a 16-bit word stream; pairs form {second,first}.
module outpkt_csum32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] word,
    output logic [31:0] csum
);

    logic [31:0] sum;
    logic [15:0] lo;
    logic        odd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
            lo  <= '0;
            odd <= 1'b0;
        end else if (clr) begin
            sum <= '0;
            lo  <= '0;
            odd <= 1'b0;
        end else if (en) begin
            // even word is parked until its partner arrives
            if (odd) sum <= sum + {word, lo};
            else     lo  <= word;
            odd <= ~odd;
        end
    end

    assign csum = ~sum;

endmodule

// File: rtl/cmp_result_outpkt.sv
// Serializes one comparator match into a CMP_RESULT packet of 16-bit words
// with on-the-fly header and data checksums.
module cmp_result_outpkt
    import cmp_result_outpkt_pkg::*;
#(
    parameter logic [7:0] VERSION          = PKT_COMM_VERSION,
    parameter logic [7:0] PKT_TYPE         = PKT_TYPE_CMP_RESULT,
    parameter bit         INCLUDE_HASH     = 1'b1,
    parameter bit         DISABLE_CHECKSUM = 1'b0
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  pkt_id,
    input  logic [15:0]  word_id,
    input  logic [31:0]  gen_id,
    input  logic [15:0]  hash_num,
    input  logic [511:0] hash,
    output logic [15:0]  dout,
    output logic         wr_en,
    input  logic         full,
    output logic         busy
);

    localparam int          DATA_WORDS = INCLUDE_HASH ? 36 : 4;
    localparam logic [23:0] LEN        = INCLUDE_HASH ? 24'd72 : 24'd8;

    state_t       state, state_nxt;
    logic [5:0]   cnt;
    logic         last;
    logic         accept;
    ids_t         ids_r;
    logic [511:0] hash_r;
    logic [4:0]   hidx;
    logic [31:0]  hcs_raw, dcs_raw, hcs, dcs;

    assign accept = in_valid && (state == ST_IDLE);
    assign hidx   = 5'(cnt - 6'd4);

    always_comb begin
        last = 1'b0;
        case (state)
            ST_HDR:   last = (cnt == 6'(HDR_WORDS - 1));
            ST_HCSUM: last = (cnt == 6'd1);
            ST_DATA:  last = (cnt == 6'(DATA_WORDS - 1));
            ST_DCSUM: last = (cnt == 6'd1);
            default:  last = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)        state_nxt = ST_HDR;
            ST_HDR:   if (wr_en && last) state_nxt = ST_HCSUM;
            ST_HCSUM: if (wr_en && last) state_nxt = ST_DATA;
            ST_DATA:  if (wr_en && last) state_nxt = ST_DCSUM;
            ST_DCSUM: if (wr_en && last) state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_IDLE);
        busy     = (state != ST_IDLE);
        wr_en    = (state != ST_IDLE) && !full;
        dout     = '0;
        case (state)
            ST_HDR: begin
                case (cnt)
                    6'd0:    dout = {PKT_TYPE, VERSION};
                    6'd2:    dout = LEN[15:0];
                    6'd3:    dout = {8'h0, LEN[23:16]};
                    6'd4:    dout = ids_r.pkt_id;
                    default: dout = '0;
                endcase
            end
            ST_HCSUM: dout = cnt[0] ? hcs[31:16] : hcs[15:0];
            ST_DATA: begin
                case (cnt)
                    6'd0:    dout = ids_r.word_id;
                    6'd1:    dout = ids_r.gen_id[15:0];
                    6'd2:    dout = ids_r.gen_id[31:16];
                    6'd3:    dout = ids_r.hash_num;
                    default: dout = hash_r[{hidx, 4'b0} +: 16];
                endcase
            end
            ST_DCSUM: dout = cnt[0] ? dcs[31:16] : dcs[15:0];
            default:  dout = '0;
        endcase
    end

    // counter restarts on every state entry, advances only on a written word
    always_ff @(posedge CLK or posedge rst) begin
        if (rst)                     cnt <= '0;
        else if (accept)             cnt <= '0;
        else if (wr_en && last)      cnt <= '0;
        else if (wr_en)              cnt <= cnt + 6'd1;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            ids_r  <= '0;
            hash_r <= '0;
        end else if (accept) begin
            ids_r  <= '{pkt_id: pkt_id, word_id: word_id, gen_id: gen_id, hash_num: hash_num};
            hash_r <= hash;
        end
    end

    outpkt_csum32 u_hcsum (
        .clk  (CLK),
        .rst  (rst),
        .clr  (accept),
        .en   (wr_en && (state == ST_HDR)),
        .word (dout),
        .csum (hcs_raw)
    );

    outpkt_csum32 u_dcsum (
        .clk  (CLK),
        .rst  (rst),
        .clr  (accept),
        .en   (wr_en && (state == ST_DATA)),
        .word (dout),
        .csum (dcs_raw)
    );

    assign hcs = DISABLE_CHECKSUM ? 32'h0 : hcs_raw;
    assign dcs = DISABLE_CHECKSUM ? 32'h0 : dcs_raw;

endmodule

// File: tb/tb_cmp_result_outpkt.sv
// Directed bench: IDs-only, with-hash and checksum-disabled instances on shared inputs.
module tb_cmp_result_outpkt;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   in_valid;
    logic [15:0]  pkt_id, word_id, hash_num;
    logic [31:0]  gen_id;
    logic [511:0] hash;
    logic         full;

    logic         rdy0, rdy1, rdy2, busy0, busy1, busy2, wr0, wr1, wr2;
    logic [15:0]  dout0, dout1, dout2;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int viol = 0;
    int low0 = 0;
    logic [15:0] q0[$], q1[$], q2[$];
    int t0[$];
    int acc_t[$];

    logic [15:0] exp_nh [14];
    logic [15:0] exp_h  [46];

    always #5 clk = ~clk;

    cmp_result_outpkt #(.INCLUDE_HASH(1'b0), .DISABLE_CHECKSUM(1'b0)) u_nh (
        .CLK(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(rdy0),
        .pkt_id(pkt_id), .word_id(word_id), .gen_id(gen_id), .hash_num(hash_num),
        .hash(hash), .dout(dout0), .wr_en(wr0), .full(full), .busy(busy0));

    cmp_result_outpkt #(.INCLUDE_HASH(1'b1), .DISABLE_CHECKSUM(1'b0)) u_h (
        .CLK(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(rdy1),
        .pkt_id(pkt_id), .word_id(word_id), .gen_id(gen_id), .hash_num(hash_num),
        .hash(hash), .dout(dout1), .wr_en(wr1), .full(full), .busy(busy1));

    cmp_result_outpkt #(.INCLUDE_HASH(1'b0), .DISABLE_CHECKSUM(1'b1)) u_nc (
        .CLK(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(rdy2),
        .pkt_id(pkt_id), .word_id(word_id), .gen_id(gen_id), .hash_num(hash_num),
        .hash(hash), .dout(dout2), .wr_en(wr2), .full(full), .busy(busy2));

    always @(posedge clk) cyc <= cyc + 1;

    // a word sampled with wr_en high here is written on the coming edge
    always @(negedge clk) begin
        if (wr0) begin q0.push_back(dout0); t0.push_back(cyc); end
        if (wr1) q1.push_back(dout1);
        if (wr2) q2.push_back(dout2);
        if ((wr0 || wr1 || wr2) && full) viol++;
        if (in_valid[0] && rdy0) acc_t.push_back(cyc);
        if (!rdy0) low0++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int sel);
        case (sel)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic send(input int sel);
        @(posedge clk); #1;
        in_valid[sel] = 1'b1;
        @(posedge clk); #1;
        in_valid[sel] = 1'b0;
    endtask

    task automatic wait_q(input int sel, input int target);
        int k = 0;
        while (qsize(sel) < target && k < 500) begin
            @(posedge clk);
            k++;
        end
        chk("wait_words", 32'(qsize(sel) >= target), 32'd1);
        repeat (3) @(posedge clk);
        chk("word_count", qsize(sel), target);
    endtask

    task automatic check_seq(input string tag, input int sel, input int base);
        int n;
        logic [15:0] got, e;
        n = (sel == 1) ? 46 : 14;
        for (int i = 0; i < n; i++) begin
            case (sel)
                0:       got = q0[base+i];
                1:       got = q1[base+i];
                default: got = q2[base+i];
            endcase
            e = (sel == 1) ? exp_h[i] : exp_nh[i];
            if (sel == 2 && (i == 6 || i == 7 || i >= 12)) e = 16'h0;
            chk($sformatf("%s[%0d]", tag, i), {16'h0, got}, {16'h0, e});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base, abase, lbase, vbase, k;
        exp_nh = '{16'hD402, 16'h0000, 16'h0008, 16'h0000, 16'h0003, 16'h0000, 16'h2BF2,
                   16'hFFFF, 16'h001E, 16'h0000, 16'h0000, 16'h0196, 16'hFFE1, 16'hFE69};
        for (int i = 0; i < 46; i++) exp_h[i] = 16'h0;
        exp_h[0]  = 16'hD402; exp_h[2]  = 16'h0048; exp_h[4]  = 16'h0003;
        exp_h[6]  = 16'h2BB2; exp_h[7]  = 16'hFFFF; exp_h[8]  = 16'h001E;
        exp_h[11] = 16'h0196; exp_h[12] = 16'h27D7; exp_h[13] = 16'h93C5;
        exp_h[14] = 16'h85BA; exp_h[15] = 16'h9FA3; exp_h[44] = 16'h5250;
        exp_h[45] = 16'hCB01;

        rst = 1'b1; in_valid = '0; full = 1'b0;
        pkt_id = 16'd3; word_id = 16'd30; gen_id = 32'd0; hash_num = 16'd406;
        hash = 512'h9fa385ba93c527d7;

        @(negedge clk);
        chk("rst_in_ready", 32'(rdy0), 32'd1);
        chk("rst_busy",     32'(busy0), 32'd0);
        chk("rst_wr_en",    32'(wr1), 32'd0);
        chk("rst_dout",     32'(dout1), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // IDs-only packet, no back-pressure
        base = q0.size(); abase = acc_t.size();
        send(0);
        @(negedge clk);
        chk("t1_in_ready_drop", 32'(rdy0), 32'd0);
        chk("t1_busy",          32'(busy0), 32'd1);
        wait_q(0, base + 14);
        check_seq("t1_word", 0, base);
        chk("t1_first_latency", t0[base] - acc_t[abase], 32'd1);
        chk("t1_consecutive",   t0[base+13] - t0[base], 32'd13);

        // with hash
        base = q1.size();
        send(1);
        wait_q(1, base + 46);
        check_seq("t2_word", 1, base);

        // full toggling every other clock
        base = q0.size(); vbase = viol;
        send(0);
        k = 0;
        while (q0.size() < base + 14 && k < 200) begin
            @(posedge clk); #1 full = ~full;
            k++;
        end
        full = 1'b0;
        wait_q(0, base + 14);
        check_seq("t3_word", 0, base);
        chk("t3_wr_while_full", viol - vbase, 32'd0);

        // in_valid held high over two packets
        base = q0.size(); abase = acc_t.size(); lbase = low0;
        @(posedge clk); #1 in_valid[0] = 1'b1;
        k = 0;
        while (acc_t.size() < abase + 2 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        in_valid[0] = 1'b0;
        wait_q(0, base + 28);
        chk("t4_accepts",  acc_t.size() - abase, 32'd2);
        chk("t4_acc_gap",  acc_t[abase+1] - acc_t[abase], 32'd15);
        chk("t4_low_cyc",  low0 - lbase, 32'd28);
        check_seq("t4a_word", 0, base);
        check_seq("t4b_word", 0, base + 14);

        // reset after the fifth word
        base = q0.size();
        send(0);
        k = 0;
        while (q0.size() < base + 5 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_wr_en",    32'(wr0), 32'd0);
        chk("t5_rst_in_ready", 32'(rdy0), 32'd1);
        chk("t5_rst_busy",     32'(busy0), 32'd0);
        repeat (2) @(posedge clk);
        chk("t5_words_before", q0.size() - base, 32'd5);
        #1 rst = 1'b0;
        send(0);
        wait_q(0, base + 19);
        check_seq("t5_word", 0, base + 5);

        // checksums disabled
        base = q2.size();
        send(2);
        wait_q(2, base + 14);
        check_seq("t6_word", 2, base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
